// File: rtl/prim_generic_ram_2p.sv
// Generic true dual-port RAM: masked writes, optional output register, selectable cross-port read-during-write data.
// Same-address write-write resolves per group in favour of port A and pulses collision_o when groups overlap.
module prim_generic_ram_2p #(
  parameter int Width           = 32,
  parameter int Depth           = 128,
  parameter int DataBitsPerMask = 1,
  parameter bit OutputReg       = 1'b0,
  parameter bit ReadNewData     = 1'b0,
  parameter int Aw              = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_req_i,
  input  logic             a_write_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Width-1:0] a_wmask_i,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  input  logic             b_req_i,
  input  logic             b_write_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  input  logic [Width-1:0] b_wmask_i,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,
  output logic             collision_o
);

  localparam int NumGroups = Width / DataBitsPerMask;
  localparam int DepthI = Depth;
  localparam logic [Aw:0] DepthW = DepthI[Aw:0];

  logic [Width-1:0] mem [Depth];

  logic [1:0]       req, wr, inr, we, re;
  logic [Aw-1:0]    addr  [2];
  logic [Width-1:0] wdata [2];
  logic [Width-1:0] wmask [2];
  logic [Width-1:0] bmask [2];
  logic [Width-1:0] old   [2];
  logic [Width-1:0] wword [2];
  logic [Width-1:0] rword [2];
  logic [Width-1:0] a_final, b_only;
  logic             same_addr, wr_both;

  logic [1:0]       s1_vld;
  logic [Width-1:0] s1_dat [2];

  assign req      = {b_req_i, a_req_i};
  assign wr       = {b_write_i, a_write_i};
  assign addr[0]  = a_addr_i;
  assign addr[1]  = b_addr_i;
  assign wdata[0] = a_wdata_i;
  assign wdata[1] = b_wdata_i;
  assign wmask[0] = a_wmask_i;
  assign wmask[1] = b_wmask_i;

  always_comb begin
    inr = '0;
    we  = '0;
    re  = '0;
    for (int p = 0; p < 2; p++) begin
      inr[p] = {1'b0, addr[p]} < DepthW;
      we[p]  = req[p] & wr[p] & inr[p];
      re[p]  = req[p] & ~wr[p];
    end
  end

  // A group is written only when every bit of its mask slice is set.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      bmask[p] = '0;
      for (int g = 0; g < NumGroups; g++) begin
        bmask[p][g*DataBitsPerMask +: DataBitsPerMask] =
          {DataBitsPerMask{&wmask[p][g*DataBitsPerMask +: DataBitsPerMask]}};
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      old[p]   = inr[p] ? mem[addr[p]] : '0;
      wword[p] = (old[p] & ~bmask[p]) | (wdata[p] & bmask[p]);
    end
  end

  assign same_addr = (addr[0] == addr[1]);
  assign wr_both   = we[0] & we[1] & same_addr;
  assign b_only    = bmask[1] & ~bmask[0];
  // On a shared-address double write, port A carries the merged word and B's write is dropped.
  assign a_final   = wr_both ? ((wword[0] & ~b_only) | (wdata[1] & b_only)) : wword[0];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rword[p] = (ReadNewData && we[1-p] && same_addr) ? wword[1-p] : old[p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we[0]) mem[addr[0]] <= a_final;
    if (we[1] && !wr_both) mem[addr[1]] <= wword[1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld      <= '0;
      s1_dat[0]   <= '0;
      s1_dat[1]   <= '0;
      collision_o <= 1'b0;
    end else begin
      s1_vld      <= re;
      collision_o <= wr_both & (|(bmask[0] & bmask[1]));
      for (int p = 0; p < 2; p++) begin
        if (re[p]) s1_dat[p] <= rword[p];
      end
    end
  end

  if (OutputReg) begin : g_oreg
    logic [1:0]       s2_vld;
    logic [Width-1:0] s2_dat [2];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s2_vld    <= '0;
        s2_dat[0] <= '0;
        s2_dat[1] <= '0;
      end else begin
        s2_vld <= s1_vld;
        for (int p = 0; p < 2; p++) begin
          if (s1_vld[p]) s2_dat[p] <= s1_dat[p];
        end
      end
    end

    assign a_rvalid_o = s2_vld[0];
    assign b_rvalid_o = s2_vld[1];
    assign a_rdata_o  = s2_dat[0];
    assign b_rdata_o  = s2_dat[1];
  end else begin : g_noreg
    assign a_rvalid_o = s1_vld[0];
    assign b_rvalid_o = s1_vld[1];
    assign a_rdata_o  = s1_dat[0];
    assign b_rdata_o  = s1_dat[1];
  end

endmodule
